// File: rtl/stereo_frame_sequencer_if.sv
// Paired left/right pixel stream handshake in front of the stereo frame sequencer.
interface stereo_frame_sequencer_if #(
   parameter int N = 8
);
   logic         s_l_valid;
   logic [N-1:0] s_l_data;
   logic         s_l_ready;
   logic         s_r_valid;
   logic [N-1:0] s_r_data;
   logic         s_r_ready;

   modport master (
      output s_l_valid, s_l_data, s_r_valid, s_r_data,
      input  s_l_ready, s_r_ready
   );

   modport slave (
      input  s_l_valid, s_l_data, s_r_valid, s_r_data,
      output s_l_ready, s_r_ready
   );
endinterface

// File: rtl/stereo_frame_sequencer.sv
// Frame controller for the stereo matching core: pairs left/right pixels,
// appends zero flush rows, waits for the core output to go quiet, and
// tracks disparities emitted per frame.
module stereo_frame_sequencer #(
   parameter int M          = 450,
   parameter int ROWS       = 375,
   parameter int N          = 8,
   parameter int D          = 64,
   parameter int FLUSH_ROWS = 7,
   parameter int IDLE_TO    = 256,
   localparam int DBIT      = $clog2(D)
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [DBIT-1:0]         i_thresh,
   stereo_frame_sequencer_if.slave pix,
   output logic [N-1:0]            o_core_data_l,
   output logic [N-1:0]            o_core_data_r,
   output logic                    o_core_dval,
   output logic [DBIT-1:0]         o_core_thresh,
   input  logic                    i_core_dval,
   input  logic [DBIT-1:0]         i_core_data,
   output logic                    o_disp_valid,
   output logic [DBIT-1:0]         o_disp_data,
   output logic [31:0]             o_disp_count,
   output logic                    o_busy,
   output logic                    o_done
);

   typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;

   localparam int FLUSH_LEN = FLUSH_ROWS * M;
   localparam int CW        = (M > 1) ? $clog2(M) : 1;
   localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FW        = $clog2(FLUSH_LEN + 1);
   localparam int QW        = $clog2(IDLE_TO + 1);

   localparam logic [CW-1:0] COL_LAST   = CW'(M - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
   localparam logic [QW-1:0] QUIET_LAST = QW'(IDLE_TO - 1);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [FW-1:0] flush_cnt;
   logic [QW-1:0] quiet_cnt;
   logic          accept;
   logic          start_ok;
   logic          last_pixel;
   logic          flush_end;

   // A pair is taken only when both sides are valid together; abort blocks it
   assign accept     = (state == STREAM) && pix.s_l_valid && pix.s_r_valid && !i_abort;
   assign start_ok   = (state == IDLE) && i_start;
   assign last_pixel = accept && (col == COL_LAST) && (row == ROW_LAST);
   assign flush_end  = (state == FLUSH) && (flush_cnt == FLUSH_LAST);

   assign pix.s_l_ready = accept;
   assign pix.s_r_ready = accept;

   // Frame state register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state decode with abort overriding every transition, plus status flags
   always_comb begin
      state_next = state;
      o_busy     = (state != IDLE);
      o_done     = (state == DONE);
      case (state)
         IDLE:    if (i_start) state_next = STREAM;
         STREAM:  if (last_pixel) state_next = FLUSH;
         FLUSH:   if (flush_end) state_next = DRAIN;
         DRAIN:   if (!i_core_dval && (quiet_cnt == QUIET_LAST)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (i_abort && (state != IDLE)) state_next = IDLE;
   end

   // Position, flush and quiet counters; all freeze on abort until the next start
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         col       <= '0;
         row       <= '0;
         flush_cnt <= '0;
         quiet_cnt <= '0;
      end else if (start_ok) begin
         col       <= '0;
         row       <= '0;
         flush_cnt <= '0;
         quiet_cnt <= '0;
      end else if (!i_abort) begin
         if (accept) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
         if (flush_end) quiet_cnt <= '0;
         else if (state == DRAIN) quiet_cnt <= i_core_dval ? '0 : quiet_cnt + 1'b1;
      end
   end

   // Pixel pair register toward the core: real pairs in STREAM, zeros in FLUSH
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_core_dval   <= 1'b0;
         o_core_data_l <= '0;
         o_core_data_r <= '0;
      end else begin
         o_core_dval <= accept || ((state == FLUSH) && !i_abort);
         if (accept) begin
            o_core_data_l <= pix.s_l_data;
            o_core_data_r <= pix.s_r_data;
         end else if ((state == FLUSH) && !i_abort) begin
            o_core_data_l <= '0;
            o_core_data_r <= '0;
         end
      end
   end

   // Threshold is captured once per frame so the core sees a stable value
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)       o_core_thresh <= '0;
      else if (start_ok) o_core_thresh <= i_thresh;
   end

   // Disparity output register and saturating per-frame disparity count
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_disp_valid <= 1'b0;
         o_disp_data  <= '0;
         o_disp_count <= '0;
      end else begin
         o_disp_valid <= i_core_dval;
         o_disp_data  <= i_core_data;
         if (start_ok) o_disp_count <= '0;
         else if (i_core_dval && (o_disp_count != 32'hFFFF_FFFF)) o_disp_count <= o_disp_count + 1'b1;
      end
   end

endmodule
